ysyx_22040750_mem_stage: RTL and testbench

Memory-access stage of the full-pipeline RV64 core: sits between the EX/MEM pipeline register and the MEM/WB register and drives the data-memory bus for loads and stores. A four-state FSM issues one request per memory instruction and waits for the bus response. It then presents the raw 64-bit beat, byte shift amount and valid to MEM/WB. Non-memory instructions pass straight through with zero added latency. The upstream stage stalls via O_EX_MEM_allowin until the access has been handed to MEM/WB.

---
 rtl/ysyx_22040750_mem_stage.sv | 147 ++++++++++++++
 tb/tb_ysyx_22040750_mem_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040750_mem_stage.sv
// Memory-access stage: issues one data-bus request per load/store and hands
// the raw beat plus byte shift to MEM/WB. Non-memory ops pass straight through.
//
// Handshakes (valid/ready): O_MEM_WB_valid/I_MEM_WB_allowin transfer when both
// are high. I_EX_MEM_valid/O_EX_MEM_allowin transfer when both are high, and
// upstream holds every I_* field stable while allowin is low. O_bus_req/
// I_bus_ack transfer when both are high, and req is never withdrawn before ack.
// I_bus_rvalid is a one-cycle data strobe with no backpressure.
module ysyx_22040750_mem_stage (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic        I_EX_MEM_valid,
    output logic        O_EX_MEM_allowin,
    input  logic        I_mem_ren,
    input  logic        I_mem_wen,
    input  logic [31:0] I_addr,
    input  logic [63:0] I_wdata,
    input  logic [7:0]  I_wstrb,
    output logic        O_MEM_WB_valid,
    input  logic        I_MEM_WB_allowin,
    output logic [63:0] O_mem_data,
    output logic [2:0]  O_mem_shamt,
    output logic        O_bus_req,
    output logic        O_bus_we,
    output logic [31:0] O_bus_addr,
    output logic [63:0] O_bus_wdata,
    output logic [7:0]  O_bus_wstrb,
    input  logic        I_bus_ack,
    input  logic        I_bus_rvalid,
    input  logic [63:0] I_bus_rdata,
    output logic [1:0]  O_dbg_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] WAIT_R = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]  state_q,   state_d;
    logic        we_q,      we_d;
    logic [31:0] addr_q,    addr_d;
    logic [63:0] wdata_q,   wdata_d;
    logic [7:0]  wstrb_q,   wstrb_d;
    logic [63:0] rdata_q,   rdata_d;
    logic        bus_req_q, bus_req_d;

    logic mem_op;

    // A valid instruction that touches memory; ren&wen together counts as a store.
    assign mem_op = I_EX_MEM_valid & (I_mem_ren | I_mem_wen);

    // Next-state logic for the access FSM and its latch registers.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    we_d    = I_mem_wen;
                    addr_d  = I_addr;
                    wdata_d = I_wdata;
                    wstrb_d = I_wstrb;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (I_bus_ack) begin
                    state_d = we_q ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (I_bus_rvalid) begin
                    rdata_d = I_bus_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (I_MEM_WB_allowin) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Request line is a register: high exactly while the FSM sits in REQ.
        bus_req_d = (state_d == REQ);
    end

    // State and latch registers with synchronous active-high reset.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 64'd0;
            wstrb_q   <= 8'd0;
            rdata_q   <= 64'd0;
            bus_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            bus_req_q <= bus_req_d;
        end
    end

    // Pipeline-facing outputs: pass-through in IDLE, stall until DONE hands off.
    always_comb begin
        O_MEM_WB_valid   = 1'b0;
        O_EX_MEM_allowin = 1'b0;
        O_mem_data       = 64'd0;
        O_mem_shamt      = addr_q[2:0];
        case (state_q)
            IDLE: begin
                O_mem_shamt = I_addr[2:0];
                if (!mem_op) begin
                    O_MEM_WB_valid   = I_EX_MEM_valid;
                    O_EX_MEM_allowin = I_MEM_WB_allowin;
                end
            end
            DONE: begin
                O_MEM_WB_valid   = 1'b1;
                O_EX_MEM_allowin = I_MEM_WB_allowin;
                O_mem_data       = we_q ? 64'd0 : rdata_q;
            end
            default: begin
                O_MEM_WB_valid   = 1'b0;
                O_EX_MEM_allowin = 1'b0;
            end
        endcase
    end

    // Bus fields come only from the latched registers so they stay stable until ack.
    assign O_bus_req   = bus_req_q;
    assign O_bus_we    = we_q;
    assign O_bus_addr  = {addr_q[31:3], 3'b000};
    assign O_bus_wdata = wdata_q;
    assign O_bus_wstrb = wstrb_q;
    assign O_dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_22040750_mem_stage.sv
// Directed bench for the memory-access stage: reset, ALU pass-through, load,
// delayed-ack store, MEM/WB stall in DONE, load-then-ALU, reset during WAIT_R.
module tb_ysyx_22040750_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_allowin;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wb_valid;
    logic        wb_allowin;
    logic [63:0] mem_data;
    logic [2:0]  mem_shamt;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_ack;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;
    logic [1:0]  dbg_state;

    int n_cmp;
    int n_fail;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    ysyx_22040750_mem_stage dut (
        .I_sys_clk        (clk),
        .I_rst            (rst),
        .I_EX_MEM_valid   (ex_valid),
        .O_EX_MEM_allowin (ex_allowin),
        .I_mem_ren        (ren),
        .I_mem_wen        (wen),
        .I_addr           (addr),
        .I_wdata          (wdata),
        .I_wstrb          (wstrb),
        .O_MEM_WB_valid   (wb_valid),
        .I_MEM_WB_allowin (wb_allowin),
        .O_mem_data       (mem_data),
        .O_mem_shamt      (mem_shamt),
        .O_bus_req        (bus_req),
        .O_bus_we         (bus_we),
        .O_bus_addr       (bus_addr),
        .O_bus_wdata      (bus_wdata),
        .O_bus_wstrb      (bus_wstrb),
        .I_bus_ack        (bus_ack),
        .I_bus_rvalid     (bus_rvalid),
        .I_bus_rdata      (bus_rdata),
        .O_dbg_state      (dbg_state)
    );

    // Clock: posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs, away from the edge.
    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        ex_valid   = 1'b0;
        ren        = 1'b0;
        wen        = 1'b0;
        addr       = 32'd0;
        wdata      = 64'd0;
        wstrb      = 8'd0;
        bus_ack    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 64'd0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst        = 1'b1;
        wb_allowin = 1'b1;
        drive_idle();

        // ---------------- reset ----------------
        tick();
        tick();
        settle();
        chk("rst_state",   64'(dbg_state),  64'(S_IDLE));
        chk("rst_bus_req", 64'(bus_req),    64'd0);
        chk("rst_bus_we",  64'(bus_we),     64'd0);
        chk("rst_bus_addr",64'(bus_addr),   64'd0);
        chk("rst_data",    mem_data,        64'd0);
        chk("rst_wbvalid", 64'(wb_valid),   64'd0);
        chk("rst_allowin", 64'(ex_allowin), 64'd1);
        rst = 1'b0;
        tick();

        // ---------------- ALU pass-through, 4 cycles ----------------
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1;
            addr     = 32'h0000_1000 + 32'(i);
            settle();
            chk("alu_wbvalid", 64'(wb_valid),   64'd1);
            chk("alu_allowin", 64'(ex_allowin), 64'd1);
            chk("alu_bus_req", 64'(bus_req),    64'd0);
            chk("alu_data",    mem_data,        64'd0);
            chk("alu_shamt",   64'(mem_shamt),  64'(i));
            tick();
        end

        // ---------------- load 0x8000_0013, ack immediately ----------------
        ex_valid = 1'b1;
        ren      = 1'b1;
        addr     = 32'h8000_0013;
        settle();
        chk("ld_idle_allowin", 64'(ex_allowin), 64'd0);
        chk("ld_idle_wbvalid", 64'(wb_valid),   64'd0);
        tick();
        bus_ack = 1'b1;
        settle();
        chk("ld_req_state",   64'(dbg_state),  64'(S_REQ));
        chk("ld_req",         64'(bus_req),    64'd1);
        chk("ld_req_addr",    64'(bus_addr),   64'h8000_0010);
        chk("ld_req_we",      64'(bus_we),     64'd0);
        chk("ld_req_allowin", 64'(ex_allowin), 64'd0);
        tick();
        bus_ack    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 64'h1122_3344_5566_7788;
        settle();
        chk("ld_wait_state",   64'(dbg_state),  64'(S_WAIT_R));
        chk("ld_wait_req",     64'(bus_req),    64'd0);
        chk("ld_wait_allowin", 64'(ex_allowin), 64'd0);
        chk("ld_wait_wbvalid", 64'(wb_valid),   64'd0);
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = 64'd0;
        settle();
        chk("ld_done_state",   64'(dbg_state),  64'(S_DONE));
        chk("ld_done_wbvalid", 64'(wb_valid),   64'd1);
        chk("ld_done_data",    mem_data,        64'h1122_3344_5566_7788);
        chk("ld_done_shamt",   64'(mem_shamt),  64'd3);
        chk("ld_done_allowin", 64'(ex_allowin), 64'd1);
        tick();

        // ALU op released by the handoff passes through the very next cycle
        ren  = 1'b0;
        addr = 32'h0000_2006;
        settle();
        chk("ld_alu_state",   64'(dbg_state),  64'(S_IDLE));
        chk("ld_alu_wbvalid", 64'(wb_valid),   64'd1);
        chk("ld_alu_allowin", 64'(ex_allowin), 64'd1);
        chk("ld_alu_data",    mem_data,        64'd0);
        chk("ld_alu_shamt",   64'(mem_shamt),  64'd6);
        tick();

        // ---------------- store 0x8000_0008, ack after 3 cycles ----------------
        ex_valid = 1'b1;
        wen      = 1'b1;
        addr     = 32'h8000_0008;
        wdata    = 64'h0000_0000_DEAD_BEEF;
        wstrb    = 8'h0F;
        settle();
        chk("st_idle_allowin", 64'(ex_allowin), 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_ack = (i == 3);
            settle();
            chk("st_req_state", 64'(dbg_state), 64'(S_REQ));
            chk("st_req",       64'(bus_req),   64'd1);
            chk("st_req_we",    64'(bus_we),    64'd1);
            chk("st_req_addr",  64'(bus_addr),  64'h8000_0008);
            chk("st_req_wdata", bus_wdata,      64'h0000_0000_DEAD_BEEF);
            chk("st_req_wstrb", 64'(bus_wstrb), 64'h0F);
            chk("st_req_allowin", 64'(ex_allowin), 64'd0);
            tick();
        end
        bus_ack = 1'b0;
        settle();
        chk("st_done_state",   64'(dbg_state),  64'(S_DONE));
        chk("st_done_req",     64'(bus_req),    64'd0);
        chk("st_done_wbvalid", 64'(wb_valid),   64'd1);
        chk("st_done_data",    mem_data,        64'd0);
        chk("st_done_shamt",   64'(mem_shamt),  64'd0);
        chk("st_done_allowin", 64'(ex_allowin), 64'd1);
        tick();

        // ---------------- load stalled 5 cycles in DONE ----------------
        drive_idle();
        ex_valid   = 1'b1;
        ren        = 1'b1;
        addr       = 32'h8000_0026;
        wb_allowin = 1'b0;
        settle();
        chk("stl_idle_state", 64'(dbg_state), 64'(S_IDLE));
        tick();
        bus_ack = 1'b1;
        tick();
        bus_ack    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 64'hA5A5_0000_FFFF_1234;
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = 64'd0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stl_state",   64'(dbg_state),  64'(S_DONE));
            chk("stl_wbvalid", 64'(wb_valid),   64'd1);
            chk("stl_data",    mem_data,        64'hA5A5_0000_FFFF_1234);
            chk("stl_shamt",   64'(mem_shamt),  64'd6);
            chk("stl_allowin", 64'(ex_allowin), 64'd0);
            tick();
        end
        wb_allowin = 1'b1;
        settle();
        chk("stl_rel_allowin", 64'(ex_allowin), 64'd1);
        chk("stl_rel_data",    mem_data,        64'hA5A5_0000_FFFF_1234);
        tick();
        drive_idle();
        settle();
        chk("stl_after_state", 64'(dbg_state), 64'(S_IDLE));
        tick();

        // ---------------- reset during WAIT_R, late rvalid ----------------
        ex_valid = 1'b1;
        ren      = 1'b1;
        addr     = 32'h8000_0040;
        tick();
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        rst     = 1'b1;
        settle();
        chk("rw_pre_state", 64'(dbg_state), 64'(S_WAIT_R));
        tick();
        rst        = 1'b0;
        ren        = 1'b0;
        addr       = 32'h0000_3001;
        bus_rvalid = 1'b1;
        bus_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        settle();
        chk("rw_state",   64'(dbg_state),  64'(S_IDLE));
        chk("rw_req",     64'(bus_req),    64'd0);
        chk("rw_wbvalid", 64'(wb_valid),   64'd1);
        chk("rw_allowin", 64'(ex_allowin), 64'd1);
        chk("rw_data",    mem_data,        64'd0);
        tick();
        bus_rvalid = 1'b0;
        bus_rdata  = 64'd0;
        ex_valid   = 1'b0;
        settle();
        chk("rw_after_state",   64'(dbg_state), 64'(S_IDLE));
        chk("rw_after_req",     64'(bus_req),   64'd0);
        chk("rw_after_wbvalid", 64'(wb_valid),  64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
